// File: rtl/l1_dm_line_seq.sv
// Line sequencer: streams whole cache lines between the L1 data-memory SRAM and the fill/evict ports.
// Optional macro L1_DM_SEQ_WRAP_EN: each line starts at CMD_WORD and wraps (critical-word-first).
module l1_dm_line_seq #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 1024,
    parameter int LINE_WORDS = 4,
    localparam int LW_B      = $clog2(LINE_WORDS),
    localparam int ADDR_B    = $clog2(DEPTH),
    localparam int LINE_B    = $clog2(DEPTH / LINE_WORDS),
    localparam int CNT_B     = LW_B + 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CMD_VAL,
    output logic                 CMD_RDY,
    input  logic                 CMD_TYPE,
    input  logic [LINE_B-1:0]    CMD_LINE,
    input  logic [LW_B-1:0]      CMD_WORD,
    input  logic                 FILL_VAL,
    output logic                 FILL_RDY,
    input  logic [WIDTH-1:0]     FILL_DATA,
    output logic                 EVICT_VAL,
    input  logic                 EVICT_RDY,
    output logic [WIDTH-1:0]     EVICT_DATA,
    output logic                 EVICT_LAST,
    output logic                 DONE,
    output logic                 MEM_EN,
    output logic                 MEM_WE,
    output logic [ADDR_B-1:0]    MEM_ADDR,
    output logic [WIDTH/8-1:0]   MEM_WBE,
    output logic [WIDTH-1:0]     MEM_WDATA,
    input  logic [WIDTH-1:0]     MEM_RDATA
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_EVICT} state_t;

    localparam logic [CNT_B-1:0] LAST_BEAT = CNT_B'(LINE_WORDS - 1);
    localparam logic [CNT_B-1:0] ALL_BEATS = CNT_B'(LINE_WORDS);

    state_t                  state_q, state_d;
    logic [LINE_B-1:0]       line_q, line_d;
    logic [LW_B-1:0]         start_q, start_d;
    logic [CNT_B-1:0]        beat_q, beat_d;
    logic [CNT_B-1:0]        iss_q, iss_d;
    logic                    infl_q, infl_d;
    logic [1:0]              occ_q, occ_d;
    logic                    wr_q, wr_d;
    logic                    rd_q, rd_d;
    logic [1:0][WIDTH-1:0]   fifo_q, fifo_d;
    logic                    done_q, done_d;

    logic [LW_B-1:0]         cmd_start;
    logic [LW_B-1:0]         fill_off;
    logic [LW_B-1:0]         rd_off;
    logic                    issue, pop, store, deq;

`ifdef L1_DM_SEQ_WRAP_EN
    assign cmd_start = CMD_WORD;
`else
    logic unused_cmd_word;
    assign cmd_start       = '0;
    assign unused_cmd_word = ^CMD_WORD;
`endif

    assign fill_off = start_q + beat_q[LW_B-1:0];
    assign rd_off   = start_q + iss_q[LW_B-1:0];

    assign CMD_RDY  = (state_q == S_IDLE);
    assign FILL_RDY = (state_q == S_FILL);
    assign DONE     = done_q;

    // Read data arriving while the FIFO is empty bypasses straight to the head,
    // so a word is visible the cycle its SRAM read returns.
    assign EVICT_VAL  = (state_q == S_EVICT) && ((occ_q != 2'd0) || infl_q);
    assign EVICT_DATA = (occ_q != 2'd0) ? fifo_q[rd_q] : MEM_RDATA;
    assign EVICT_LAST = EVICT_VAL && (beat_q == LAST_BEAT);
    assign pop        = EVICT_VAL && EVICT_RDY;

    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        start_d   = start_q;
        beat_d    = beat_q;
        iss_d     = iss_q;
        infl_d    = 1'b0;
        occ_d     = occ_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        fifo_d    = fifo_q;
        done_d    = 1'b0;
        issue     = 1'b0;
        store     = 1'b0;
        deq       = 1'b0;
        MEM_EN    = 1'b0;
        MEM_WE    = 1'b0;
        MEM_ADDR  = '0;
        MEM_WBE   = '0;
        MEM_WDATA = '0;

        case (state_q)
            S_IDLE: begin
                if (CMD_VAL) begin
                    line_d  = CMD_LINE;
                    start_d = cmd_start;
                    beat_d  = '0;
                    iss_d   = '0;
                    occ_d   = '0;
                    wr_d    = 1'b0;
                    rd_d    = 1'b0;
                    state_d = CMD_TYPE ? S_EVICT : S_FILL;
                end
            end
            S_FILL: begin
                if (FILL_VAL) begin
                    MEM_EN    = 1'b1;
                    MEM_WE    = 1'b1;
                    MEM_WBE   = '1;
                    MEM_ADDR  = {line_q, fill_off};
                    MEM_WDATA = FILL_DATA;
                    beat_d    = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_EVICT: begin
                // Words held plus reads in flight never exceed the two FIFO slots.
                issue = (iss_q != ALL_BEATS) &&
                        ((occ_q == 2'd0) || ((occ_q == 2'd1) && !infl_q));
                if (issue) begin
                    MEM_EN   = 1'b1;
                    MEM_ADDR = {line_q, rd_off};
                    iss_d    = iss_q + 1'b1;
                    infl_d   = 1'b1;
                end
                if (occ_q == 2'd0) begin
                    store = infl_q && !pop;
                end else begin
                    store = infl_q;
                    deq   = pop;
                end
                if (store) begin
                    fifo_d[wr_q] = MEM_RDATA;
                    wr_d         = ~wr_q;
                end
                if (deq)
                    rd_d = ~rd_q;
                occ_d = occ_q + 2'(store) - 2'(deq);
                if (pop) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            line_q  <= '0;
            start_q <= '0;
            beat_q  <= '0;
            iss_q   <= '0;
            infl_q  <= 1'b0;
            occ_q   <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            fifo_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            start_q <= start_d;
            beat_q  <= beat_d;
            iss_q   <= iss_d;
            infl_q  <= infl_d;
            occ_q   <= occ_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            fifo_q  <= fifo_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_l1_dm_line_seq.sv
// Randomized bench for l1_dm_line_seq: an SRAM model plus a line-level reference memory.
module tb_l1_dm_line_seq;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 1024;
    localparam int LW     = 4;
    localparam int LW_B   = 2;
    localparam int ADDR_B = 10;
    localparam int LINE_B = 8;

    logic                CLK = 1'b0;
    logic                RST;
    logic                CMD_VAL, CMD_RDY, CMD_TYPE;
    logic [LINE_B-1:0]   CMD_LINE;
    logic [LW_B-1:0]     CMD_WORD;
    logic                FILL_VAL, FILL_RDY;
    logic [WIDTH-1:0]    FILL_DATA;
    logic                EVICT_VAL, EVICT_RDY, EVICT_LAST;
    logic [WIDTH-1:0]    EVICT_DATA;
    logic                DONE;
    logic                MEM_EN, MEM_WE;
    logic [ADDR_B-1:0]   MEM_ADDR;
    logic [WIDTH/8-1:0]  MEM_WBE;
    logic [WIDTH-1:0]    MEM_WDATA;
    logic [WIDTH-1:0]    MEM_RDATA;

    l1_dm_line_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LINE_WORDS(LW)) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VAL(CMD_VAL), .CMD_RDY(CMD_RDY), .CMD_TYPE(CMD_TYPE),
        .CMD_LINE(CMD_LINE), .CMD_WORD(CMD_WORD),
        .FILL_VAL(FILL_VAL), .FILL_RDY(FILL_RDY), .FILL_DATA(FILL_DATA),
        .EVICT_VAL(EVICT_VAL), .EVICT_RDY(EVICT_RDY), .EVICT_DATA(EVICT_DATA),
        .EVICT_LAST(EVICT_LAST), .DONE(DONE),
        .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WBE(MEM_WBE),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
    );

    always #5 CLK = ~CLK;

    // SRAM with one-cycle read latency
    logic [WIDTH-1:0] sram [DEPTH];
    always @(posedge CLK) begin
        if (RST) MEM_RDATA <= '0;
        else if (MEM_EN && !MEM_WE) MEM_RDATA <= sram[MEM_ADDR];
        if (MEM_EN && MEM_WE) sram[MEM_ADDR] <= MEM_WDATA;
    end

    logic [WIDTH-1:0] ref_mem [DEPTH];
    logic [WIDTH-1:0] fdat [LW];
    int filled_q[$];
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    function automatic int start_of(input int word);
`ifdef L1_DM_SEQ_WRAP_EN
        return word;
`else
        return 0;
`endif
    endfunction

    function automatic int waddr(input int line, input int s, input int k);
        return line * LW + ((s + k) % LW);
    endfunction

    // Fill fdat[] into a line; returns in the DONE cycle with DONE already checked.
    task automatic do_fill(input int line, input int word, input bit nostall);
        int s, c, b, a;
        s = start_of(word);
        CMD_VAL = 1; CMD_TYPE = 0; CMD_LINE = LINE_B'(line); CMD_WORD = LW_B'(word);
        FILL_VAL = 0; EVICT_RDY = 0;
        #1 chk("fill_cmd_rdy", CMD_RDY, 1);
        tick;
        CMD_VAL = 0;
        c = 1; b = 0;
        while (b < LW && c < 200) begin
            FILL_VAL  = nostall ? 1'b1 : ($urandom_range(0, 3) != 0);
            FILL_DATA = FILL_VAL ? fdat[b] : $urandom;
            #1;
            chk("fill_rdy", FILL_RDY, 1);
            chk("fill_done_early", DONE, 0);
            if (FILL_VAL) begin
                a = waddr(line, s, b);
                chk("fill_en_we", {MEM_EN, MEM_WE}, 2'b11);
                chk("fill_wbe", MEM_WBE, 4'hF);
                chk("fill_addr", MEM_ADDR, a);
                chk("fill_wdata", MEM_WDATA, fdat[b]);
                ref_mem[a] = fdat[b];
                b++;
            end else begin
                chk("fill_stall_en", MEM_EN, 0);
            end
            tick;
            c++;
        end
        if (b < LW) chk("fill_timeout", b, LW);
        FILL_VAL = 0;
        #1;
        chk("fill_done", DONE, 1);
        chk("fill_done_cmd_rdy", CMD_RDY, 1);
        chk("fill_done_rdy_low", FILL_RDY, 0);
    endtask

    // mode 0: ready always high; 1: ready low on cycles 2..7; 2: random ready
    task automatic do_evict(input int line, input int word, input int mode);
        int s, c, iss, pops;
        s = start_of(word);
        CMD_VAL = 1; CMD_TYPE = 1; CMD_LINE = LINE_B'(line); CMD_WORD = LW_B'(word);
        FILL_VAL = 0; EVICT_RDY = 0;
        #1 chk("ev_cmd_rdy", CMD_RDY, 1);
        tick;
        CMD_VAL = 0;
        c = 1; iss = 0; pops = 0;
        while (pops < LW && c < 200) begin
            case (mode)
                0: EVICT_RDY = 1'b1;
                1: EVICT_RDY = !(c >= 2 && c <= 7);
                default: EVICT_RDY = ($urandom_range(0, 2) != 0);
            endcase
            #1;
            chk("ev_done_early", DONE, 0);
            if (mode == 0) chk("ev_issue_cycle", MEM_EN, c <= LW);
            if (mode == 0 && c <= 2) chk("ev_val_first", EVICT_VAL, c == 2);
            if (MEM_EN) begin
                chk("ev_rd_we_wbe", {MEM_WE, MEM_WBE}, 0);
                chk("ev_rd_addr", MEM_ADDR, waddr(line, s, iss));
                iss++;
                chk("ev_outstanding_le2", (iss - pops) <= 2, 1);
                chk("ev_issue_le_line", iss <= LW, 1);
            end
            if (EVICT_VAL && EVICT_RDY) begin
                chk("ev_data", EVICT_DATA, ref_mem[waddr(line, s, pops)]);
                chk("ev_last", EVICT_LAST, pops == LW - 1);
                pops++;
            end
            tick;
            c++;
        end
        if (pops < LW) chk("ev_timeout", pops, LW);
        EVICT_RDY = 0;
        #1;
        chk("ev_done", DONE, 1);
        chk("ev_done_cmd_rdy", CMD_RDY, 1);
        chk("ev_done_val_low", EVICT_VAL, 0);
        if (mode == 0) chk("ev_done_cycle", c, LW + 2);
    endtask

    task automatic mark_filled(input int line);
        foreach (filled_q[i]) if (filled_q[i] == line) return;
        filled_q.push_back(line);
    endtask

    initial begin
        int op, line, gap;
        RST = 1; CMD_VAL = 0; CMD_TYPE = 0; CMD_LINE = '0; CMD_WORD = '0;
        FILL_VAL = 0; FILL_DATA = '0; EVICT_RDY = 0;
        repeat (3) tick;
        RST = 0;
        #1;
        chk("rst_cmd_rdy", CMD_RDY, 1);
        chk("rst_fill_rdy", FILL_RDY, 0);
        chk("rst_evict_val_last", {EVICT_VAL, EVICT_LAST}, 0);
        chk("rst_done", DONE, 0);
        chk("rst_mem_en_we_wbe", {MEM_EN, MEM_WE, MEM_WBE}, 0);
        chk("rst_mem_addr", MEM_ADDR, 0);
        chk("rst_mem_wdata", MEM_WDATA, 0);
        tick;

        // stray stream handshakes in IDLE are ignored
        FILL_VAL = 1; EVICT_RDY = 1; FILL_DATA = 32'hDEAD_BEEF;
        #1;
        chk("idle_fill_ignored", MEM_EN, 0);
        chk("idle_evict_val", EVICT_VAL, 0);
        tick;
        FILL_VAL = 0; EVICT_RDY = 0;

        // line 5 fill then back-to-back evict in the DONE cycle
        for (int i = 0; i < LW; i++) fdat[i] = 32'hA0 + i;
        do_fill(5, 0, 1);
        mark_filled(5);
        do_evict(5, 0, 0);
        tick;
        do_evict(5, 0, 1);
        tick;

        // critical-word start on line 0
        for (int i = 0; i < LW; i++) fdat[i] = 32'hB0 + i;
        do_fill(0, 2, 1);
        mark_filled(0);
        do_evict(0, 2, 0);
        tick;

        // reset during the second fill beat
        CMD_VAL = 1; CMD_TYPE = 0; CMD_LINE = 8'd9; CMD_WORD = '0;
        tick;
        CMD_VAL = 0; FILL_VAL = 1; FILL_DATA = 32'hC0;
        tick;
        FILL_DATA = 32'hC1; RST = 1;
        #1 chk("rstmid_beat_en", MEM_EN, 1);
        tick;
        RST = 0; FILL_DATA = 32'hC2;
        #1;
        chk("rstmid_mem_en", MEM_EN, 0);
        chk("rstmid_done", DONE, 0);
        chk("rstmid_cmd_rdy", CMD_RDY, 1);
        chk("rstmid_fill_rdy", FILL_RDY, 0);
        tick;
        FILL_VAL = 0;
        #1 chk("rstmid_done_after", DONE, 0);
        tick;

        // random traffic
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 1);
            if (op == 0 || filled_q.size() == 0) begin
                line = $urandom_range(0, 255);
                for (int i = 0; i < LW; i++) fdat[i] = $urandom;
                do_fill(line, $urandom_range(0, LW - 1), $urandom_range(0, 1));
                mark_filled(line);
            end else begin
                line = filled_q[$urandom_range(0, filled_q.size() - 1)];
                do_evict(line, $urandom_range(0, LW - 1), $urandom_range(0, 2));
            end
            gap = $urandom_range(0, 2);
            CMD_VAL = 0; FILL_VAL = 0; EVICT_RDY = 0;
            if (gap == 0) continue;
            tick;
            for (int g = 1; g < gap; g++) begin
                #1 chk("gap_idle_en", MEM_EN, 0);
                tick;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
